// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: RV32I multi-cycle sequencing FSM with req/ack memory handshake.
// Define MC_MEM_TIMEOUT_EN to build the memory timeout counter and mem_err.
module multicycle_ctrl #(
  parameter int TIMEOUT_CYC = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instruction,
  input  logic        br_taken,
  input  logic        mem_ack,
  output logic        mem_req,
  output logic        mem_we,
  output logic        mem_addr_sel,
  output logic        ir_wren,
  output logic        mdr_wren,
  output logic        pc_wren,
  output logic        rd_wren,
  output logic        pc_sel,
  output logic        op1_sel,
  output logic        op2_sel,
  output logic        alu_force_add,
  output logic [1:0]  wb_sel,
  output logic        instr_retired,
  output logic        illegal_instr,
  output logic        mem_err,
  output logic [2:0]  state_dbg
);
  typedef enum logic [2:0] {
    BOOT = 3'd0, FETCH = 3'd1, DECODE = 3'd2, EXEC = 3'd3, MEM = 3'd4, WB = 3'd5, HALT = 3'd7
  } state_t;
  state_t state, state_nxt;
  logic [6:0] op;
  logic is_r, is_i, is_ld, is_st, is_br, is_jal, is_jalr, is_lui, is_auipc, legal, jump;
  logic op1, op2, timeout, ill_q;
  logic unused_instr;
  assign op           = instruction[6:0];
  assign unused_instr = ^instruction[31:7];
  assign is_r     = op == 7'b0110011;
  assign is_i     = op == 7'b0010011;
  assign is_ld    = op == 7'b0000011;
  assign is_st    = op == 7'b0100011;
  assign is_br    = op == 7'b1100011;
  assign is_jal   = op == 7'b1101111;
  assign is_jalr  = op == 7'b1100111;
  assign is_lui   = op == 7'b0110111;
  assign is_auipc = op == 7'b0010111;
  assign legal    = is_r | is_i | is_ld | is_st | is_br | is_jal | is_jalr | is_lui | is_auipc;
  assign jump     = is_jal | is_jalr;
  // Operand mapping: PC-relative ops take PC on op1; everything but R-type takes imm on op2.
  assign op1 = is_br | is_jal | is_auipc;
  assign op2 = ~is_r;
`ifdef MC_MEM_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  logic [CW-1:0] cnt;
  logic err_q;
  // Counts unacknowledged request cycles; zero whenever no request is waiting.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else cnt <= (mem_req && !mem_ack) ? cnt + 1'b1 : '0;
  assign timeout = mem_req && !mem_ack && cnt == CW'(TIMEOUT_CYC - 1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) err_q <= 1'b0;
    else err_q <= err_q | timeout;
  assign mem_err = err_q;
`else
  localparam int unused_timeout = TIMEOUT_CYC;
  assign timeout = 1'b0;
  assign mem_err = 1'b0;
`endif
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= BOOT;
      ill_q <= 1'b0;
    end else begin
      state <= state_nxt;
      ill_q <= ill_q | (state == DECODE && !legal);
    end
  assign illegal_instr = ill_q;
  assign state_dbg     = state;
  always_comb begin
    state_nxt     = state;
    mem_req       = 1'b0;
    mem_we        = 1'b0;
    mem_addr_sel  = 1'b0;
    ir_wren       = 1'b0;
    mdr_wren      = 1'b0;
    pc_wren       = 1'b0;
    rd_wren       = 1'b0;
    pc_sel        = 1'b0;
    op1_sel       = 1'b0;
    op2_sel       = 1'b0;
    alu_force_add = 1'b0;
    wb_sel        = 2'b00;
    instr_retired = 1'b0;
    case (state)
      BOOT: state_nxt = FETCH;
      FETCH: begin
        mem_req   = 1'b1;
        ir_wren   = mem_ack;
        state_nxt = mem_ack ? DECODE : timeout ? HALT : FETCH;
      end
      DECODE: state_nxt = legal ? EXEC : HALT;
      EXEC: begin
        op1_sel       = op1;
        op2_sel       = op2;
        alu_force_add = is_ld | is_st | is_br;
        pc_wren       = is_br;
        pc_sel        = is_br & br_taken;
        instr_retired = is_br;
        state_nxt     = (is_ld | is_st) ? MEM : is_br ? FETCH : WB;
      end
      MEM: begin
        mem_req       = 1'b1;
        mem_addr_sel  = 1'b1;
        mem_we        = is_st;
        op1_sel       = op1;
        op2_sel       = op2;
        alu_force_add = 1'b1;
        mdr_wren      = mem_ack & is_ld;
        pc_wren       = mem_ack & is_st;
        instr_retired = mem_ack & is_st;
        state_nxt     = mem_ack ? (is_st ? FETCH : WB) : timeout ? HALT : MEM;
      end
      WB: begin
        op1_sel       = op1;
        op2_sel       = op2;
        rd_wren       = 1'b1;
        pc_wren       = 1'b1;
        instr_retired = 1'b1;
        pc_sel        = jump;
        wb_sel        = is_ld ? 2'b11 : jump ? 2'b10 : 2'b00;
        state_nxt     = FETCH;
      end
      HALT: state_nxt = HALT;
      default: state_nxt = HALT;
    endcase
  end
endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: scoreboard bench for multicycle_ctrl (TIMEOUT_CYC=8).
module tb_multicycle_ctrl;
  logic clk = 1'b0, rst_n = 1'b0, br_taken = 1'b0, mem_ack = 1'b0;
  logic [31:0] instruction = 32'h0;
  logic mem_req, mem_we, mem_addr_sel, ir_wren, mdr_wren, pc_wren, rd_wren, pc_sel;
  logic op1_sel, op2_sel, alu_force_add, instr_retired, illegal_instr, mem_err;
  logic [1:0] wb_sel;
  logic [2:0] state_dbg;
  logic [18:0] obs;
  int n_checks = 0, n_errors = 0;
  typedef struct { string tag; logic [18:0] v; } exp_t;
  exp_t sb[$];
  localparam logic [18:0] S0 = 19'h00000, S1 = 19'h10000, S2 = 19'h20000, S3 = 19'h30000;
  localparam logic [18:0] S4 = 19'h40000, S5 = 19'h50000, S7 = 19'h70000;
  localparam logic [18:0] REQ = 19'h8000, WE = 19'h4000, ASEL = 19'h2000, IR = 19'h1000;
  localparam logic [18:0] MDR = 19'h0800, PC = 19'h0400, RD = 19'h0200, PSEL = 19'h0100;
  localparam logic [18:0] O1 = 19'h0080, O2 = 19'h0040, FA = 19'h0020, WB10 = 19'h0010;
  localparam logic [18:0] WB11 = 19'h0018, RET = 19'h0004, ILL = 19'h0002, ERR = 19'h0001;
  multicycle_ctrl #(.TIMEOUT_CYC(8)) dut (
    .clk(clk), .rst_n(rst_n), .instruction(instruction), .br_taken(br_taken),
    .mem_ack(mem_ack), .mem_req(mem_req), .mem_we(mem_we), .mem_addr_sel(mem_addr_sel),
    .ir_wren(ir_wren), .mdr_wren(mdr_wren), .pc_wren(pc_wren), .rd_wren(rd_wren),
    .pc_sel(pc_sel), .op1_sel(op1_sel), .op2_sel(op2_sel), .alu_force_add(alu_force_add),
    .wb_sel(wb_sel), .instr_retired(instr_retired), .illegal_instr(illegal_instr),
    .mem_err(mem_err), .state_dbg(state_dbg)
  );
  assign obs = {state_dbg, mem_req, mem_we, mem_addr_sel, ir_wren, mdr_wren, pc_wren, rd_wren,
                pc_sel, op1_sel, op2_sel, alu_force_add, wb_sel, instr_retired, illegal_instr, mem_err};
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [18:0] got, input logic [18:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  // Drive one cycle's inputs, queue its expected outputs, compare at the falling edge.
  task automatic cyc(input string tag, input logic ack, input logic [18:0] v);
    exp_t e;
    mem_ack = ack;
    sb.push_back('{tag, v});
    @(negedge clk);
    e = sb.pop_front();
    check(e.tag, obs, e.v);
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset(input string tag);
    rst_n   = 1'b0;
    mem_ack = 1'b1;
    #1 check(tag, obs, S0);
    @(posedge clk);
    #1;
    rst_n   = 1'b1;
    mem_ack = 1'b0;
    cyc({tag, "_boot"}, 1'b0, S0);
  endtask
  initial begin
    mem_ack = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("in_reset", obs, S0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    mem_ack = 1'b0;
    cyc("boot", 1'b0, S0);
    instruction = 32'h00500093;
    cyc("addi_f", 1'b1, S1 | REQ | IR);
    cyc("addi_d", 1'b0, S2);
    cyc("addi_e", 1'b0, S3 | O2);
    cyc("addi_w", 1'b0, S5 | RD | PC | O2 | RET);
    instruction = 32'h0000A103;
    cyc("lw_f", 1'b1, S1 | REQ | IR);
    cyc("lw_d", 1'b0, S2);
    cyc("lw_e", 1'b0, S3 | O2 | FA);
    for (int i = 0; i < 3; i++) cyc("lw_mwait", 1'b0, S4 | REQ | ASEL | O2 | FA);
    cyc("lw_mack", 1'b1, S4 | REQ | ASEL | O2 | FA | MDR);
    cyc("lw_w", 1'b0, S5 | RD | PC | O2 | RET | WB11);
    instruction = 32'h0020A023;
    cyc("sw_f", 1'b1, S1 | REQ | IR);
    cyc("sw_d", 1'b0, S2);
    cyc("sw_e", 1'b0, S3 | O2 | FA);
    cyc("sw_m", 1'b1, S4 | REQ | WE | ASEL | O2 | FA | PC | RET);
    instruction = 32'h00000463;
    br_taken = 1'b1;
    cyc("beq_t_f", 1'b1, S1 | REQ | IR);
    cyc("beq_t_d", 1'b0, S2);
    cyc("beq_t_e", 1'b0, S3 | O1 | O2 | FA | PC | PSEL | RET);
    br_taken = 1'b0;
    cyc("beq_n_f", 1'b1, S1 | REQ | IR);
    cyc("beq_n_d", 1'b0, S2);
    cyc("beq_n_e", 1'b0, S3 | O1 | O2 | FA | PC | RET);
    instruction = 32'h008000EF;
    cyc("jal_fwait", 1'b0, S1 | REQ);
    cyc("jal_fwait", 1'b0, S1 | REQ);
    cyc("jal_f", 1'b1, S1 | REQ | IR);
    cyc("jal_d", 1'b0, S2);
    cyc("jal_e", 1'b0, S3 | O1 | O2);
    cyc("jal_w", 1'b0, S5 | RD | PC | PSEL | O1 | O2 | RET | WB10);
    instruction = 32'h000080E7;
    cyc("jalr_f", 1'b1, S1 | REQ | IR);
    cyc("jalr_d", 1'b0, S2);
    cyc("jalr_e", 1'b0, S3 | O2);
    cyc("jalr_w", 1'b0, S5 | RD | PC | PSEL | O2 | RET | WB10);
    instruction = 32'h002081B3;
    cyc("add_f", 1'b1, S1 | REQ | IR);
    cyc("add_d", 1'b0, S2);
    cyc("add_e", 1'b0, S3);
    cyc("add_w", 1'b0, S5 | RD | PC | RET);
    instruction = 32'h0000A103;
    cyc("rst_lw_f", 1'b1, S1 | REQ | IR);
    cyc("rst_lw_d", 1'b0, S2);
    cyc("rst_lw_e", 1'b0, S3 | O2 | FA);
    cyc("rst_lw_m", 1'b0, S4 | REQ | ASEL | O2 | FA);
    #2 do_reset("rst_mid_mem");
    cyc("post_rst_f", 1'b0, S1 | REQ);
    instruction = 32'h0000007F;
    cyc("ill_f", 1'b1, S1 | REQ | IR);
    cyc("ill_d", 1'b0, S2);
    for (int i = 0; i < 100; i++) cyc("ill_halt", 1'($urandom_range(0, 1)), S7 | ILL);
    do_reset("ill_clear");
    instruction = 32'h00500093;
`ifdef MC_MEM_TIMEOUT_EN
    for (int i = 0; i < 8; i++) cyc("to_wait", 1'b0, S1 | REQ);
    cyc("to_halt", 1'b0, S7 | ERR);
    cyc("to_halt2", 1'b1, S7 | ERR);
    do_reset("to_clear");
    for (int i = 0; i < 7; i++) cyc("to8_wait", 1'b0, S1 | REQ);
    cyc("to8_ack", 1'b1, S1 | REQ | IR);
    cyc("to8_d", 1'b0, S2);
    cyc("to8_e", 1'b0, S3 | O2);
`else
    for (int i = 0; i < 1000; i++) cyc("no_to_wait", 1'b0, S1 | REQ);
    cyc("no_to_ack", 1'b1, S1 | REQ | IR);
    cyc("no_to_d", 1'b0, S2);
`endif
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
